// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port and memory-side burst port of the cacheline adaptor.
// slave = adaptor, master = the cache/memory environment driving it.
interface cacheline_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
);
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Splits a cacheline read/write into a BEATS-beat memory burst and reassembles
// read bursts into one line, answering the cache with a single-cycle resp_o.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input logic clk,
  input logic rst,
  cacheline_adaptor_if.slave bus
);
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W       = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                               state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q;
  logic [BEATS-1:0][BURST_WIDTH-1:0]    line_q;
  logic [ADDR_WIDTH-1:0]                addr_q;
  logic                                 last_beat;

  assign last_beat  = bus.resp_i && (cnt_q == CNT_W'(BEATS - 1));
  assign bus.line_o = line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Address offset bits are cleared at capture so address_o is line-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      line_q <= '0;
      addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.write_i) begin
            line_q <= bus.line_i;
            addr_q <= {bus.address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          end else if (bus.read_i) begin
            addr_q <= {bus.address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          end
        end
        READ: if (bus.resp_i) begin
          line_q[cnt_q] <= bus.burst_i;
          cnt_q         <= cnt_q + 1'b1;
        end
        WRITE: if (bus.resp_i) cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.read_o    = 1'b0;
    bus.write_o   = 1'b0;
    bus.resp_o    = 1'b0;
    bus.burst_o   = '0;
    bus.address_o = '0;
    case (state_q)
      IDLE: begin
        if (bus.write_i)     state_d = WRITE;
        else if (bus.read_i) state_d = READ;
      end
      READ: begin
        bus.read_o    = 1'b1;
        bus.address_o = addr_q;
        if (last_beat) state_d = DONE;
      end
      WRITE: begin
        bus.write_o   = 1'b1;
        bus.burst_o   = line_q[cnt_q];
        bus.address_o = addr_q;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        bus.resp_o    = 1'b1;
        bus.address_o = addr_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
